// File: rtl/joystick_pkg.sv
// Shared types and constants for the joystick ADC sequencer: FSM states, ADC0832 frame layout, axis codes.
package joystick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } state_t;

  localparam int CMD_BITS   = 3;
  localparam int MUX_BITS   = 1;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 12;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DATA_BITS-1:0] AXIS_CENTER = 8'h80;

  localparam logic CH_X = 1'b0;
  localparam logic CH_Y = 1'b1;

  // Command word is start=1, SGL=1, ODD=channel; every later frame bit drives 0.
  function automatic logic cmd_bit(input logic [BIT_W-1:0] b, input logic ch);
    if (b < BIT_W'(CMD_BITS - 1)) return 1'b1;
    if (b == BIT_W'(CMD_BITS - 1)) return ch;
    return 1'b0;
  endfunction

endpackage

// File: rtl/adc_frame_shifter.sv
// One ADC0832 frame: start-bit setup, 12 mode-0 SCLK periods, command out on mosi, 8 data bits in from miso.
module adc_frame_shifter
  import joystick_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 ch,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 setup_end,
  output logic                 done,
  output logic [DATA_BITS-1:0] data
);

  localparam int HW = $clog2(CLK_DIV);

  logic [HW-1:0]        half_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 active;
  logic                 in_setup;
  logic                 ch_q;
  logic [1:0]           miso_sync;
  logic [DATA_BITS-2:0] shreg;
  logic                 half_end;
  logic                 sample;

  // Data bits are taken on the last clk of each high half so the synchroniser
  // has settled on the bit the ADC launched at the preceding falling edge.
  always_comb begin
    half_end  = active && (half_cnt == HW'(CLK_DIV - 1));
    setup_end = half_end && in_setup;
    sample    = half_end && !in_setup && sclk && (bit_cnt >= BIT_W'(CMD_BITS + MUX_BITS));
    done      = half_end && !in_setup && sclk && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    data      = {shreg, miso_sync[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt  <= '0;
      bit_cnt   <= '0;
      active    <= 1'b0;
      in_setup  <= 1'b0;
      ch_q      <= CH_X;
      miso_sync <= '0;
      shreg     <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      if (start) begin
        active   <= 1'b1;
        in_setup <= 1'b1;
        half_cnt <= '0;
        bit_cnt  <= '0;
        ch_q     <= ch;
        sclk     <= 1'b0;
        mosi     <= cmd_bit('0, ch);
      end else if (active) begin
        half_cnt <= half_end ? '0 : half_cnt + 1'b1;
        if (sample) shreg <= data[DATA_BITS-2:0];
        if (half_end) begin
          if (in_setup) begin
            in_setup <= 1'b0;
          end else if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            if (done) begin
              active <= 1'b0;
              mosi   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi    <= cmd_bit(bit_cnt + 1'b1, ch_q);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/joystick_adc_sequencer.sv
// Time-shares one serial 8-bit ADC between joystick X (ch0) and Y (ch1), one X/Y pair per sample period.
module joystick_adc_sequencer
  import joystick_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int CS_IDLE       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 adc_miso_i,
  output logic                 adc_cs_n_o,
  output logic                 adc_sclk_o,
  output logic                 adc_mosi_o,
  output logic [DATA_BITS-1:0] x_o,
  output logic [DATA_BITS-1:0] y_o,
  output logic                 x_valid_o,
  output logic                 y_valid_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int GW = $clog2(CS_IDLE + 1);

  state_t               state;
  logic [TW-1:0]        timer;
  logic [GW-1:0]        gap_cnt;
  logic                 ch;
  logic                 trigger;
  logic                 gap_end;
  logic                 start;
  logic                 start_ch;
  logic                 setup_end;
  logic                 done;
  logic [DATA_BITS-1:0] data;

  always_comb begin
    trigger  = en_i && (timer == TW'(SAMPLE_PERIOD - 1));
    gap_end  = (state == ST_GAP) && (gap_cnt == GW'(CS_IDLE - 1));
    start    = ((state == ST_IDLE) && trigger) || gap_end;
    start_ch = (state == ST_GAP) ? CH_Y : CH_X;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) timer <= '0;
    else if (en_i) timer <= trigger ? '0 : timer + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      ch         <= CH_X;
      adc_cs_n_o <= 1'b1;
      x_o        <= AXIS_CENTER;
      y_o        <= AXIS_CENTER;
      x_valid_o  <= 1'b0;
      y_valid_o  <= 1'b0;
      busy_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      x_valid_o <= 1'b0;
      y_valid_o <= 1'b0;
      // A wrap outside IDLE is dropped; the next pair waits for the following wrap.
      if (trigger && state != ST_IDLE) overrun_o <= 1'b1;
      case (state)
        ST_IDLE: if (trigger) begin
          state      <= ST_SETUP;
          ch         <= start_ch;
          adc_cs_n_o <= 1'b0;
          busy_o     <= 1'b1;
        end
        ST_SETUP: if (setup_end) state <= ST_SHIFT;
        ST_SHIFT: if (done) begin
          state      <= ST_LATCH;
          adc_cs_n_o <= 1'b1;
          if (ch == CH_X) begin
            x_o       <= data;
            x_valid_o <= 1'b1;
          end else begin
            y_o       <= data;
            y_valid_o <= 1'b1;
            busy_o    <= 1'b0;
          end
        end
        ST_LATCH: begin
          gap_cnt <= '0;
          state   <= (ch == CH_X) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: if (gap_end) begin
          state      <= ST_SETUP;
          ch         <= start_ch;
          adc_cs_n_o <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  adc_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .start     (start),
    .ch        (start_ch),
    .miso      (adc_miso_i),
    .sclk      (adc_sclk_o),
    .mosi      (adc_mosi_o),
    .setup_end (setup_end),
    .done      (done),
    .data      (data)
  );

endmodule
